// File: rtl/cache_assoc.sv
// Blocking 1/2-way set-associative cache with LRU replacement and write-back or
// write-through policy, placed between the pipeline and a 128-bit line memory.
module cache_assoc #(
    parameter int SETS       = 4,
    parameter int WAYS       = 2,
    parameter int WRITE_BACK = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        WTHRU     = 2'd3
    } state_t;

    state_t                        r_state;
    logic [127:0]                  r_data [WAYS][SETS];
    logic [TAG_W-1:0]              r_tag  [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0]     r_valid;
    logic [WAYS-1:0][SETS-1:0]     r_dirty;
    logic [SETS-1:0]               r_lru;
    logic                          r_victim;
    logic                          r_wt_done;
    logic                          r_mem_read;
    logic                          r_mem_write;
    logic [27:0]                   r_mem_addr;
    logic [127:0]                  r_mem_wdata;

    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [WAYS-1:0]  w_hit_vec;
    logic             w_hit;
    logic             w_hit_way;
    logic             w_victim;
    logic             w_vdirty;
    logic [127:0]     w_line;
    logic [127:0]     w_wline;
    logic [127:0]     w_vline;
    logic [31:0]      w_word;
    logic             w_idle;
    logic             w_req;
    logic             w_wt_need;
    logic             w_done;

    assign w_off = proc_addr[1:0];
    assign w_idx = proc_addr[IDX_W+1:2];
    assign w_tag = proc_addr[29:IDX_W+2];

    // Per-way tag compare for the addressed set
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
        end
    end

    assign w_hit     = |w_hit_vec;
    assign w_hit_way = (WAYS == 32'sd2) && w_hit_vec[WAYS-1];

    // Replacement choice: an empty way first (way0 preferred), otherwise the LRU way
    always_comb begin
        if (WAYS == 32'sd1) begin
            w_victim = 1'b0;
        end else if (!r_valid[0][w_idx]) begin
            w_victim = 1'b0;
        end else if (!r_valid[WAYS-1][w_idx]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_idx];
        end
    end

    assign w_line   = r_data[w_hit_way][w_idx];
    assign w_word   = w_line[{w_off, 5'd0} +: 32];
    assign w_vline  = r_data[w_victim][w_idx];
    assign w_vdirty = (WRITE_BACK == 32'sd1) && r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    // Hit line with the processor word merged in
    always_comb begin
        w_wline = w_line;
        w_wline[{w_off, 5'd0} +: 32] = proc_wdata;
    end

    assign w_idle = (r_state == IDLE);
    assign w_req  = proc_read | proc_write;
    // A write-through write must reach memory once per request before it completes
    assign w_wt_need = (WRITE_BACK == 32'sd0) && (!r_wt_done || (w_word != proc_wdata));
    assign w_done    = w_idle && w_req && w_hit && !(proc_write && w_wt_need);

    assign proc_stall = !w_idle || (w_req && !w_done);
    assign proc_rdata = (w_done && !proc_write) ? w_word : 32'd0;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    // Line and tag storage, updated by write hits and by completed fills
    always_ff @(posedge clk) begin
        if (w_idle && proc_write && w_hit) begin
            r_data[w_hit_way][w_idx] <= w_wline;
        end else if ((r_state == ALLOCATE) && mem_ready) begin
            r_data[r_victim][w_idx] <= mem_rdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

    // Control FSM with valid/dirty/LRU bookkeeping and the registered memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_lru       <= '0;
            r_victim    <= 1'b0;
            r_wt_done   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 28'd0;
            r_mem_wdata <= 128'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!proc_write) begin
                        r_wt_done <= 1'b0;
                    end
                    if (w_done) begin
                        r_wt_done <= 1'b0;
                        if (WAYS == 32'sd2) begin
                            r_lru[w_idx] <= ~w_hit_way;
                        end
                        if (proc_write && (WRITE_BACK == 32'sd1)) begin
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        end
                    end else if (w_req && w_hit) begin
                        r_state     <= WTHRU;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= proc_addr[29:2];
                        r_mem_wdata <= w_wline;
                    end else if (w_req) begin
                        r_victim <= w_victim;
                        if (w_vdirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][w_idx], w_idx};
                            r_mem_wdata <= w_vline;
                        end else begin
                            r_state    <= ALLOCATE;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= proc_addr[29:2];
                        r_state     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_mem_read <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                WTHRU: begin
                    if (mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_wt_done   <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc: three configurations (2-way write-back, 2-way write-through,
// direct-mapped 8 sets) checked against a recency-based cache model and a shadow memory.
module tb_cache_assoc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]         rst_n, pr_read, pr_write, mready;
    logic [2:0][29:0]   pr_addr;
    logic [2:0][31:0]   pr_wdata;
    logic [2:0][127:0]  mrdata;
    wire  [2:0]         stall, mread, mwrite;
    wire  [2:0][31:0]   rdata;
    wire  [2:0][27:0]   maddr;
    wire  [2:0][127:0]  mwdata;

    cache_assoc #(.SETS(4), .WAYS(2), .WRITE_BACK(1)) u_wb (
        .clk(clk), .rst_n(rst_n[0]), .proc_read(pr_read[0]), .proc_write(pr_write[0]),
        .proc_addr(pr_addr[0]), .proc_wdata(pr_wdata[0]), .proc_rdata(rdata[0]),
        .proc_stall(stall[0]), .mem_read(mread[0]), .mem_write(mwrite[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]), .mem_ready(mready[0]));
    cache_assoc #(.SETS(4), .WAYS(2), .WRITE_BACK(0)) u_wt (
        .clk(clk), .rst_n(rst_n[1]), .proc_read(pr_read[1]), .proc_write(pr_write[1]),
        .proc_addr(pr_addr[1]), .proc_wdata(pr_wdata[1]), .proc_rdata(rdata[1]),
        .proc_stall(stall[1]), .mem_read(mread[1]), .mem_write(mwrite[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]), .mem_ready(mready[1]));
    cache_assoc #(.SETS(8), .WAYS(1), .WRITE_BACK(1)) u_dm (
        .clk(clk), .rst_n(rst_n[2]), .proc_read(pr_read[2]), .proc_write(pr_write[2]),
        .proc_addr(pr_addr[2]), .proc_wdata(pr_wdata[2]), .proc_rdata(rdata[2]),
        .proc_stall(stall[2]), .mem_read(mread[2]), .mem_write(mwrite[2]), .mem_addr(maddr[2]),
        .mem_wdata(mwdata[2]), .mem_rdata(mrdata[2]), .mem_ready(mready[2]));

    int sets_c [3] = '{4, 4, 8};
    int ways_c [3] = '{2, 2, 1};
    int wb_c   [3] = '{1, 0, 1};

    logic [127:0] truth  [3][64];
    logic [127:0] memarr [3][64];
    bit           m_v     [3][8][2];
    int           m_tag   [3][8][2];
    bit           m_dirty [3][8][2];
    int           m_t     [3][8][2];
    int           now;
    int           n_chk, n_fail;
    int           exp_w[$], exp_a[$];
    logic [127:0] exp_d[$];
    int           log_w[$], log_a[$];
    logic [127:0] log_d[$];
    int           last_cyc;
    logic [31:0]  last_rdata;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_v[d][s][w] = 1'b0;
                m_dirty[d][s][w] = 1'b0;
            end
        end
        for (int l = 0; l < 64; l++) truth[d][l] = memarr[d][l];
    endtask

    task automatic reset_dut(input int d);
        rst_n[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[d] = 1'b1;
        model_reset(d);
    endtask

    // One processor request, held until completion, with the memory side served inline
    task automatic access(input int d, input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, input int lat_fix);
        int line, set, tag, slot, chains, cnt, lat, sumlat, n, off, vline, cyc;
        bit hit, done;
        logic [31:0] exp_rd;
        line = int'(a[29:2]);
        off  = int'(a[1:0]);
        set  = line % sets_c[d];
        tag  = line / sets_c[d];
        exp_w.delete(); exp_a.delete(); exp_d.delete();
        log_w.delete(); log_a.delete(); log_d.delete();
        hit = 1'b0; slot = 0; chains = 0;
        for (int s = 0; s < ways_c[d]; s++)
            if (m_v[d][set][s] && m_tag[d][set][s] == tag) begin hit = 1'b1; slot = s; end
        if (!hit) begin
            slot = -1;
            for (int s = ways_c[d] - 1; s >= 0; s--) if (!m_v[d][set][s]) slot = s;
            if (slot < 0) begin
                slot = 0;
                for (int s = 1; s < ways_c[d]; s++) if (m_t[d][set][s] < m_t[d][set][slot]) slot = s;
            end
            if (m_v[d][set][slot] && m_dirty[d][set][slot]) begin
                vline = m_tag[d][set][slot] * sets_c[d] + set;
                exp_w.push_back(1); exp_a.push_back(vline); exp_d.push_back(truth[d][vline]);
            end
            exp_w.push_back(0); exp_a.push_back(line); exp_d.push_back(128'd0);
            chains = 1;
            m_v[d][set][slot] = 1'b1; m_tag[d][set][slot] = tag; m_dirty[d][set][slot] = 1'b0;
        end
        exp_rd = truth[d][line][off*32 +: 32];
        if (wr) begin
            truth[d][line][off*32 +: 32] = wd;
            if (wb_c[d] == 1) m_dirty[d][set][slot] = 1'b1;
            else begin
                exp_w.push_back(1); exp_a.push_back(line); exp_d.push_back(truth[d][line]);
                chains++;
            end
        end
        now++;
        m_t[d][set][slot] = now;

        pr_read[d] = rd; pr_write[d] = wr; pr_addr[d] = a; pr_wdata[d] = wd;
        cnt = 0; sumlat = 0; n = 0; cyc = 0; done = 1'b0;
        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
        while (!done && cyc < 100) begin
            #1;
            if (!stall[d]) begin
                done = 1'b1;
                last_rdata = rdata[d];
            end else begin
                if (mread[d] || mwrite[d]) begin
                    cnt++;
                    if (cnt >= lat) begin
                        if (n < exp_w.size()) begin
                            check("txn_write", mwrite[d], exp_w[n]);
                            check("txn_addr", maddr[d], exp_a[n]);
                            if (exp_w[n] == 1) check("txn_wdata", mwdata[d], exp_d[n]);
                        end else begin
                            check("txn_extra", n, exp_w.size());
                        end
                        log_w.push_back(int'(mwrite[d])); log_a.push_back(int'(maddr[d]));
                        log_d.push_back(mwdata[d]);
                        if (mwrite[d]) memarr[d][maddr[d][5:0]] = mwdata[d];
                        else mrdata[d] = memarr[d][maddr[d][5:0]];
                        mready[d] = 1'b1;
                        sumlat += lat; cnt = 0; n++;
                        lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
                    end
                end
                @(negedge clk);
                mready[d] = 1'b0;
                cyc++;
            end
        end
        check("done", done, 1'b1);
        check("txn_count", n, exp_w.size());
        if (done) check("latency", cyc, sumlat + chains);
        if (done && rd && !wr) check("rdata", last_rdata, exp_rd);
        last_cyc = cyc;
        @(negedge clk);
        pr_read[d] = 1'b0; pr_write[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] tmp;
        int k, line, off, r;
        bit rd, wr;
        n_chk = 0; n_fail = 0; now = 0;
        for (int d = 0; d < 3; d++)
            for (int l = 0; l < 64; l++) begin
                for (int w = 0; w < 4; w++)
                    memarr[d][l][w*32 +: 32] = 32'(l) * 32'h11111111 + 32'(w) * 32'h00100001;
                truth[d][l] = memarr[d][l];
            end
        for (int d = 0; d < 3; d++) model_reset(d);
        rst_n = 3'b000; pr_read = 3'b111; pr_write = 3'b000; mready = 3'b000;
        pr_addr = '0; pr_wdata = '0; mrdata = '0;
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_stall_req", stall[d], 1'b1);
            check("rst_mem_read", mread[d], 1'b0);
            check("rst_mem_write", mwrite[d], 1'b0);
            check("rst_rdata", rdata[d], 32'd0);
        end
        pr_read = 3'b000; #1;
        for (int d = 0; d < 3; d++) check("rst_stall_idle", stall[d], 1'b0);
        @(negedge clk);
        rst_n = 3'b111;
        @(negedge clk);

        // Cold read miss, memory answers on the third strobe cycle
        access(0, 1'b1, 1'b0, 30'h4, 32'd0, 3);
        check("t1_ntxn", log_a.size(), 1);
        check("t1_kind", log_w[0], 0);
        check("t1_addr", log_a[0], 28'h1);
        check("t1_cycles", last_cyc, 4);
        check("t1_rdata", last_rdata, 32'h11111111);

        access(0, 1'b0, 1'b1, 30'h4, 32'hDEADBEEF, 0);
        check("t2_ntxn", log_a.size(), 0);
        check("t2_cycles", last_cyc, 0);
        access(0, 1'b1, 1'b0, 30'h4, 32'd0, 0);
        check("t2_rdata", last_rdata, 32'hDEADBEEF);

        access(0, 1'b1, 1'b0, 30'h14, 32'd0, 0);
        access(0, 1'b1, 1'b0, 30'h4, 32'd0, 0);
        access(0, 1'b1, 1'b0, 30'h24, 32'd0, 0);
        check("t3_ntxn_a", log_a.size(), 1);
        check("t3_kind_a", log_w[0], 0);
        check("t3_addr_a", log_a[0], 28'h9);
        access(0, 1'b1, 1'b0, 30'h34, 32'd0, 0);
        check("t3_ntxn_b", log_a.size(), 2);
        check("t3_wb_kind", log_w[0], 1);
        check("t3_wb_addr", log_a[0], 28'h1);
        tmp = log_d[0];
        check("t3_wb_data", tmp[31:0], 32'hDEADBEEF);
        check("t3_fill_kind", log_w[1], 0);
        check("t3_fill_addr", log_a[1], 28'hD);

        access(1, 1'b1, 1'b0, 30'h4, 32'd0, 0);
        access(1, 1'b0, 1'b1, 30'h4, 32'hCAFE0000, 2);
        check("t4_ntxn", log_a.size(), 1);
        check("t4_kind", log_w[0], 1);
        check("t4_addr", log_a[0], 28'h1);
        tmp = log_d[0];
        check("t4_data", tmp[31:0], 32'hCAFE0000);
        check("t4_cycles", last_cyc, 3);

        // Reset while a fill is outstanding
        pr_addr[0] = 30'h8; pr_read[0] = 1'b1;
        k = 0;
        while (!mread[0] && k < 10) begin @(negedge clk); k++; end
        check("t5_alloc", mread[0], 1'b1);
        #2 rst_n[0] = 1'b0;
        #1;
        check("t5_mem_read_drop", mread[0], 1'b0);
        check("t5_stall", stall[0], 1'b1);
        pr_read[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n[0] = 1'b1;
        model_reset(0);
        access(0, 1'b1, 1'b0, 30'h8, 32'd0, 0);
        check("t5_ntxn", log_a.size(), 1);
        check("t5_kind", log_w[0], 0);
        check("t5_addr", log_a[0], 28'h2);

        for (int i = 0; i < 4; i++) begin
            access(2, 1'b1, 1'b0, (i % 2 == 0) ? 30'h0 : 30'h20, 32'd0, 0);
            check("t6_ntxn", log_a.size(), 1);
            check("t6_kind", log_w[0], 0);
            check("t6_addr", log_a[0], (i % 2 == 0) ? 28'h0 : 28'h8);
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200; i++) begin
                line = int'($urandom_range(0, 23));
                off  = int'($urandom_range(0, 3));
                r    = int'($urandom_range(0, 9));
                rd   = (r < 5) || (r == 9);
                wr   = (r >= 5);
                if ($urandom_range(0, 79) == 0) reset_dut(d);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                access(d, rd, wr, 30'(line * 4 + off), $urandom(), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
